// File: rtl/mwc_pkg.sv
// rtl/mwc_pkg.sv - state and fail-code encodings shared by the write checker
package mwc_pkg;

    // State bits double as the pass/fail outputs: bit 0 = PASS, bit 1 = FAIL.
    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_PASS = 2'b01;
    localparam logic [1:0] ST_FAIL = 2'b10;

    typedef logic [2:0] fail_code_t;

    localparam fail_code_t FC_NONE    = 3'd0;
    localparam fail_code_t FC_DATA    = 3'd1;
    localparam fail_code_t FC_ADDR    = 3'd2;
    localparam fail_code_t FC_TIMEOUT = 3'd3;
    localparam fail_code_t FC_ORDER   = 3'd4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mwc_match.sv
// rtl/mwc_match.sv - combinational compare of one store against the expected-store table
module mwc_match
    import mwc_pkg::*;
#(
    parameter int                      ADDR_W   = 32,
    parameter int                      DATA_W   = 32,
    parameter int                      N_EXP    = 1,
    parameter logic [N_EXP*ADDR_W-1:0] EXP_ADDR = '0,
    parameter logic [N_EXP*DATA_W-1:0] EXP_DATA = '0,
    parameter int                      ORDERED  = 1,
    parameter int                      MC_W     = $clog2(N_EXP + 1),
    parameter int                      IDX_W    = idx_width(N_EXP)
) (
    input  logic [ADDR_W-1:0] dataadr_i,
    input  logic [DATA_W-1:0] writedata_i,
    input  logic [N_EXP-1:0]  matched_i,
    input  logic [MC_W-1:0]   match_cnt_i,
    output logic [N_EXP-1:0]  addr_hit_o,
    output logic [N_EXP-1:0]  data_eq_o,
    output logic              legal_hit_o,
    output logic [IDX_W-1:0]  legal_idx_o
);

    logic [N_EXP-1:0] legal;
    logic             eq_found;

    always_comb begin
        for (int i = 0; i < N_EXP; i++) begin
            addr_hit_o[i] = (dataadr_i == EXP_ADDR[i*ADDR_W +: ADDR_W]);
            data_eq_o[i]  = (writedata_i == EXP_DATA[i*DATA_W +: DATA_W]);
            if (ORDERED != 0) begin
                legal[i] = (MC_W'(i) == match_cnt_i);
            end else begin
                legal[i] = !matched_i[i];
            end
        end
    end

    // Walk downward so lower indices overwrite higher ones; a data-equal
    // candidate always outranks a mismatching one at a duplicate address.
    always_comb begin
        legal_hit_o = 1'b0;
        legal_idx_o = '0;
        eq_found    = 1'b0;
        for (int i = N_EXP - 1; i >= 0; i--) begin
            if (legal[i] && addr_hit_o[i]) begin
                if (data_eq_o[i] || !eq_found) begin
                    legal_idx_o = IDX_W'(i);
                end
                legal_hit_o = 1'b1;
                eq_found    = eq_found | data_eq_o[i];
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - sticky pass/fail monitor for the data-memory store port
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int                      ADDR_W   = 32,
    parameter int                      DATA_W   = 32,
    parameter int                      N_EXP    = 1,
    parameter logic [N_EXP*ADDR_W-1:0] EXP_ADDR = 32'd84,
    parameter logic [N_EXP*DATA_W-1:0] EXP_DATA = 32'd7,
    parameter logic [ADDR_W-1:0]       IGN_LO   = ADDR_W'(80),
    parameter logic [ADDR_W-1:0]       IGN_HI   = ADDR_W'(80),
    parameter int                      ORDERED  = 1,
    parameter int                      TIMEOUT  = 1000,
    parameter int                      CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memwrite,
    input  logic [ADDR_W-1:0]            dataadr,
    input  logic [DATA_W-1:0]            writedata,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic [2:0]                   fail_code,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [DATA_W-1:0]            fail_data,
    output logic [$clog2(N_EXP+1)-1:0]   match_cnt,
    output logic [CNT_W-1:0]             cycle_cnt
);

    localparam int               MC_W    = $clog2(N_EXP + 1);
    localparam int               IDX_W   = idx_width(N_EXP);
    localparam logic [MC_W-1:0]  MC_LAST = MC_W'(N_EXP - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam bit               IGN_EN  = (IGN_LO <= IGN_HI);

    logic [1:0]        state_q, state_d;
    logic [N_EXP-1:0]  matched_q, matched_d;
    logic [MC_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    fail_code_t        code_q, code_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    logic [N_EXP-1:0]  addr_hit;
    logic [N_EXP-1:0]  data_eq;
    logic [N_EXP-1:0]  legal_sel;
    logic              legal_hit;
    logic              legal_eq;
    logic [IDX_W-1:0]  legal_idx;
    logic              order_hit;
    logic              in_window;

    mwc_match #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .N_EXP    (N_EXP),
        .EXP_ADDR (EXP_ADDR),
        .EXP_DATA (EXP_DATA),
        .ORDERED  (ORDERED),
        .MC_W     (MC_W),
        .IDX_W    (IDX_W)
    ) u_match (
        .dataadr_i   (dataadr),
        .writedata_i (writedata),
        .matched_i   (matched_q),
        .match_cnt_i (match_cnt_q),
        .addr_hit_o  (addr_hit),
        .data_eq_o   (data_eq),
        .legal_hit_o (legal_hit),
        .legal_idx_o (legal_idx)
    );

    always_comb begin
        for (int i = 0; i < N_EXP; i++) begin
            legal_sel[i] = legal_hit && (IDX_W'(i) == legal_idx);
        end
    end

    // In ordered mode every unmatched entry sits at or after match_cnt, and the
    // one at match_cnt is already a legal hit, so any remaining hit is out of order.
    assign legal_eq  = |(legal_sel & data_eq);
    assign order_hit = (ORDERED != 0) && |(addr_hit & ~matched_q);
    assign in_window = IGN_EN && (dataadr >= IGN_LO) && (dataadr <= IGN_HI);

    always_comb begin
        state_d     = state_q;
        matched_d   = matched_q;
        match_cnt_d = match_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        code_d      = code_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (state_q == ST_RUN) begin
            if (memwrite) begin
                if (legal_hit && legal_eq) begin
                    matched_d   = matched_q | legal_sel;
                    match_cnt_d = match_cnt_q + MC_W'(1);
                    if (match_cnt_q == MC_LAST) begin
                        state_d = ST_PASS;
                    end
                end else if (legal_hit) begin
                    state_d = ST_FAIL;
                    code_d  = FC_DATA;
                end else if (order_hit) begin
                    state_d = ST_FAIL;
                    code_d  = FC_ORDER;
                end else if (!in_window) begin
                    state_d = ST_FAIL;
                    code_d  = FC_ADDR;
                end
                if (state_d == ST_FAIL) begin
                    fail_addr_d = dataadr;
                    fail_data_d = writedata;
                end
            end
            // A store that ends the run this cycle outranks the watchdog.
            if (state_d == ST_RUN && TIMEOUT != 0 && cycle_cnt_q == TO_LAST) begin
                state_d     = ST_FAIL;
                code_d      = FC_TIMEOUT;
                fail_addr_d = '0;
                fail_data_d = '0;
            end
            if (state_d == ST_RUN && cycle_cnt_q != CNT_MAX) begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            matched_q   <= '0;
            match_cnt_q <= '0;
            cycle_cnt_q <= '0;
            code_q      <= FC_NONE;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            matched_q   <= matched_d;
            match_cnt_q <= match_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            code_q      <= code_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign pass      = state_q[0];
    assign fail      = state_q[1];
    assign done      = |state_q;
    assign fail_code = code_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign match_cnt = match_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - six checker configurations on shared stimulus, checked against a table model
module tb_mem_write_checker;

    localparam int NI = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;

    always #5 clk = ~clk;

    logic        done_w [NI];
    logic        pass_w [NI];
    logic        fail_w [NI];
    logic [2:0]  code_w [NI];
    logic [31:0] faddr_w[NI];
    logic [31:0] fdata_w[NI];
    logic [31:0] cyc_w  [NI];
    logic [31:0] mc_w   [NI];
    logic [0:0]  mc0, mc1;
    logic [1:0]  mc2, mc3;
    logic [2:0]  mc4, mc5;

    assign mc_w[0] = 32'(mc0);
    assign mc_w[1] = 32'(mc1);
    assign mc_w[2] = 32'(mc2);
    assign mc_w[3] = 32'(mc3);
    assign mc_w[4] = 32'(mc4);
    assign mc_w[5] = 32'(mc5);

    mem_write_checker u0 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .fail_code(code_w[0]),
        .fail_addr(faddr_w[0]), .fail_data(fdata_w[0]), .match_cnt(mc0), .cycle_cnt(cyc_w[0]));

    mem_write_checker #(.TIMEOUT(20)) u1 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .fail_code(code_w[1]),
        .fail_addr(faddr_w[1]), .fail_data(fdata_w[1]), .match_cnt(mc1), .cycle_cnt(cyc_w[1]));

    mem_write_checker #(.N_EXP(2), .EXP_ADDR({32'd100, 32'd84}), .EXP_DATA({32'd25, 32'd7}),
        .IGN_LO(32'd1), .IGN_HI(32'd0), .ORDERED(0), .TIMEOUT(0)) u2 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done_w[2]), .pass(pass_w[2]), .fail(fail_w[2]), .fail_code(code_w[2]),
        .fail_addr(faddr_w[2]), .fail_data(fdata_w[2]), .match_cnt(mc2), .cycle_cnt(cyc_w[2]));

    mem_write_checker #(.N_EXP(2), .EXP_ADDR({32'd100, 32'd84}), .EXP_DATA({32'd25, 32'd7}),
        .IGN_LO(32'd1), .IGN_HI(32'd0), .ORDERED(1), .TIMEOUT(0)) u3 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done_w[3]), .pass(pass_w[3]), .fail(fail_w[3]), .fail_code(code_w[3]),
        .fail_addr(faddr_w[3]), .fail_data(fdata_w[3]), .match_cnt(mc3), .cycle_cnt(cyc_w[3]));

    mem_write_checker #(.N_EXP(4), .EXP_ADDR({32'd132, 32'd120, 32'd100, 32'd84}),
        .EXP_DATA({32'd9, 32'd3, 32'd25, 32'd7}), .IGN_LO(32'd104), .IGN_HI(32'd111),
        .ORDERED(0), .TIMEOUT(25)) u4 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done_w[4]), .pass(pass_w[4]), .fail(fail_w[4]), .fail_code(code_w[4]),
        .fail_addr(faddr_w[4]), .fail_data(fdata_w[4]), .match_cnt(mc4), .cycle_cnt(cyc_w[4]));

    mem_write_checker #(.N_EXP(4), .EXP_ADDR({32'd132, 32'd120, 32'd100, 32'd84}),
        .EXP_DATA({32'd9, 32'd3, 32'd25, 32'd7}), .IGN_LO(32'd104), .IGN_HI(32'd111),
        .ORDERED(1), .TIMEOUT(25)) u5 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done_w[5]), .pass(pass_w[5]), .fail(fail_w[5]), .fail_code(code_w[5]),
        .fail_addr(faddr_w[5]), .fail_data(fdata_w[5]), .match_cnt(mc5), .cycle_cnt(cyc_w[5]));

    // Model configuration; every instance uses a prefix of the same table.
    int     cfg_n  [NI] = '{1, 1, 2, 2, 4, 4};
    int     cfg_ord[NI] = '{1, 1, 0, 1, 0, 1};
    int     cfg_to [NI] = '{1000, 20, 0, 0, 25, 25};
    longint cfg_lo [NI] = '{80, 80, 1, 1, 104, 104};
    longint cfg_hi [NI] = '{80, 80, 0, 0, 111, 111};
    int     tab_a  [4]  = '{84, 100, 120, 132};
    int     tab_d  [4]  = '{7, 25, 3, 9};

    int          m_st  [NI];
    int          m_mc  [NI];
    int          m_code[NI];
    longint      m_cyc [NI];
    logic [31:0] m_fa  [NI];
    logic [31:0] m_fd  [NI];
    bit          m_mat [NI][4];

    int n_checks = 0;
    int n_err    = 0;

    task automatic model_fail(input int k, input int code);
        m_st[k]   = 2;
        m_code[k] = code;
        m_fa[k]   = dataadr;
        m_fd[k]   = writedata;
    endtask

    task automatic model_step(input int k);
        int found;
        bit dmiss;
        bit later;
        bit legal;
        if (m_st[k] != 0) return;
        if (memwrite) begin
            found = -1;
            dmiss = 0;
            later = 0;
            for (int i = 0; i < cfg_n[k]; i++) begin
                legal = (cfg_ord[k] != 0) ? (i == m_mc[k]) : !m_mat[k][i];
                if (32'(tab_a[i]) == dataadr) begin
                    if (legal && 32'(tab_d[i]) == writedata && found < 0) found = i;
                    else if (legal) dmiss = 1;
                    else if (cfg_ord[k] != 0 && i > m_mc[k]) later = 1;
                end
            end
            if (found >= 0) begin
                m_mat[k][found] = 1;
                m_mc[k]++;
                if (m_mc[k] == cfg_n[k]) m_st[k] = 1;
            end else if (dmiss) model_fail(k, 1);
            else if (later) model_fail(k, 4);
            else if (cfg_lo[k] <= cfg_hi[k] && longint'(dataadr) >= cfg_lo[k]
                     && longint'(dataadr) <= cfg_hi[k]) begin
            end else model_fail(k, 2);
        end
        if (m_st[k] == 0 && cfg_to[k] != 0 && m_cyc[k] == longint'(cfg_to[k] - 1)) begin
            m_st[k]   = 2;
            m_code[k] = 3;
            m_fa[k]   = '0;
            m_fd[k]   = '0;
        end
        if (m_st[k] == 0 && m_cyc[k] < 64'hFFFF_FFFF) m_cyc[k]++;
    endtask

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < NI; k++) begin
            if (!reset) begin
                m_st[k] = 0; m_mc[k] = 0; m_code[k] = 0; m_cyc[k] = 0;
                m_fa[k] = '0; m_fd[k] = '0;
                for (int i = 0; i < 4; i++) m_mat[k][i] = 0;
            end else begin
                model_step(k);
            end
        end
    end

    logic [133:0] got_v, exp_v;

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            got_v = {done_w[k], pass_w[k], fail_w[k], code_w[k], mc_w[k], cyc_w[k], faddr_w[k], fdata_w[k]};
            exp_v = {m_st[k] != 0, m_st[k] == 1, m_st[k] == 2, 3'(m_code[k]), 32'(m_mc[k]),
                     32'(m_cyc[k]), m_fa[k], m_fd[k]};
            n_checks++;
            if (got_v !== exp_v) begin
                n_err++;
                if (n_err <= 40)
                    $display("FAIL model_cmp inst=%0d t=%0t got=%h expected=%h", k, $time, got_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic store(input int a, input int d);
        memwrite  = 1'b1;
        dataadr   = 32'(a);
        writedata = 32'(d);
        tick(1);
        memwrite  = 1'b0;
    endtask

    task automatic do_reset();
        tick(1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
    endtask

    int bnd[7] = '{79, 80, 81, 103, 104, 111, 112};
    int r, idx;

    initial begin
        @(negedge clk);
        check("reset_done", done_w[0], 0);
        check("reset_pass", pass_w[0], 0);
        check("reset_fail", fail_w[0], 0);
        check("reset_code", code_w[0], 0);
        check("reset_mc", mc_w[0], 0);
        tick(1);
        reset = 1'b1;

        store(80, 3);
        @(negedge clk);
        check("ignored_pass", pass_w[0], 0);
        check("ignored_fail", fail_w[0], 0);
        check("nowin_code", code_w[2], 2);
        check("nowin_addr", faddr_w[2], 80);
        store(84, 7);
        @(negedge clk);
        check("match_pass", pass_w[0], 1);
        check("match_done", done_w[0], 1);
        check("match_cnt", mc_w[0], 1);
        check("match_fail", fail_w[0], 0);

        do_reset();
        store(88, 7);
        @(negedge clk);
        check("addr_fail", fail_w[0], 1);
        check("addr_code", code_w[0], 2);
        check("addr_faddr", faddr_w[0], 88);
        check("addr_fdata", fdata_w[0], 7);
        store(84, 7);
        @(negedge clk);
        check("sticky_pass", pass_w[0], 0);
        check("sticky_fail", fail_w[0], 1);

        do_reset();
        store(84, 6);
        @(negedge clk);
        check("data_code", code_w[0], 1);
        check("data_fdata", fdata_w[0], 6);

        do_reset();
        tick(19);
        @(negedge clk);
        check("to_early_fail", fail_w[1], 0);
        tick(1);
        @(negedge clk);
        check("to_fail", fail_w[1], 1);
        check("to_code", code_w[1], 3);
        check("to_cyc", cyc_w[1], 19);
        check("to_faddr", faddr_w[1], 0);
        tick(3);
        @(negedge clk);
        check("to_cyc_frozen", cyc_w[1], 19);

        do_reset();
        tick(19);
        store(84, 7);
        @(negedge clk);
        check("to_race_pass", pass_w[1], 1);
        check("to_race_fail", fail_w[1], 0);

        do_reset();
        store(100, 25);
        @(negedge clk);
        check("order_code", code_w[3], 4);
        check("order_faddr", faddr_w[3], 100);
        check("unord_mc", mc_w[2], 1);
        store(84, 7);
        @(negedge clk);
        check("unord_pass", pass_w[2], 1);

        do_reset();
        store(84, 7);
        @(negedge clk);
        check("mid_mc", mc_w[3], 1);
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_mc", mc_w[3], 0);
        check("mid_reset_done", done_w[3], 0);
        check("mid_reset_cyc", cyc_w[3], 0);
        tick(1);
        reset = 1'b1;
        store(84, 7);
        store(100, 25);
        @(negedge clk);
        check("rerun_pass", pass_w[3], 1);

        for (int run = 0; run < 80; run++) begin
            do_reset();
            for (int c = 0; c < 30; c++) begin
                r = $urandom_range(0, 9);
                if (r < 5) begin
                    idx = (r < 3 && m_mc[5] < 4) ? m_mc[5] : $urandom_range(0, 3);
                    store(tab_a[idx], tab_d[idx]);
                end else if (r == 5) begin
                    idx = $urandom_range(0, 3);
                    store(tab_a[idx], tab_d[idx] ^ $urandom_range(1, 31));
                end else if (r == 6) begin
                    store(bnd[$urandom_range(0, 6)], $urandom_range(0, 31));
                end else if (r == 7) begin
                    store($urandom_range(80, 140), $urandom_range(0, 31));
                end else begin
                    tick(1);
                end
            end
        end

        tick(2);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
